// File: rtl/sum_window_avg.sv
// Windowed statistics over the adder-stage sum stream.
// It collects 2^LOG2_N accepted samples and reports their truncated mean, minimum,
// maximum and a running count of completed windows. Each result is held until the
// consumer accepts it with a valid/ready handshake.
module sum_window_avg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_avg,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [7:0]        win_cnt
);

  // Sized so that N samples at full scale cannot overflow
  localparam int unsigned ACC_W = DATA_W + LOG2_N;
  localparam logic [LOG2_N-1:0] CntLast = '1;

  typedef enum logic {StAcc, StHold} state_e;

  state_e             state_q;
  logic [LOG2_N-1:0]  cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic [DATA_W-1:0]  min_q;
  logic [DATA_W-1:0]  max_q;

  logic [ACC_W-1:0]   acc_sum;
  logic [DATA_W-1:0]  nxt_min;
  logic [DATA_W-1:0]  nxt_max;
  logic               accept;
  logic               last;

  // Ready depends only on state, so it never waits on in_valid or out_ready
  assign in_ready = (state_q == StAcc);
  assign accept   = in_valid && in_ready && !clear;
  assign last     = (cnt_q == CntLast);

  // Sum and running extremes as they would be if the current sample is taken
  always_comb begin
    acc_sum = acc_q + ACC_W'(in_data);
    nxt_min = min_q;
    nxt_max = max_q;
    if (cnt_q == '0) begin
      // The first sample of a window replaces both extremes
      nxt_min = in_data;
      nxt_max = in_data;
    end else begin
      if (in_data < min_q) nxt_min = in_data;
      if (in_data > max_q) nxt_max = in_data;
    end
  end

  // Window FSM with registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StAcc;
      cnt_q     <= '0;
      acc_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      out_valid <= 1'b0;
      out_avg   <= '0;
      out_min   <= '0;
      out_max   <= '0;
      win_cnt   <= '0;
    end else if (clear) begin
      // Abandon the current window. The last reported result and win_cnt stay as they are.
      state_q   <= StAcc;
      cnt_q     <= '0;
      acc_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        StAcc: begin
          if (accept) begin
            if (last) begin
              out_avg   <= acc_sum[ACC_W-1:LOG2_N];
              out_min   <= nxt_min;
              out_max   <= nxt_max;
              out_valid <= 1'b1;
              win_cnt   <= win_cnt + 8'd1;
              cnt_q     <= '0;
              acc_q     <= '0;
              min_q     <= '0;
              max_q     <= '0;
              state_q   <= StHold;
            end else begin
              acc_q <= acc_sum;
              cnt_q <= cnt_q + 1'b1;
              min_q <= nxt_min;
              max_q <= nxt_max;
            end
          end
        end
        StHold: begin
          // Input stays blocked for the handshake cycle, which leaves one bubble per window
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StAcc;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_window_avg.sv
// Scoreboard bench for sum_window_avg. The stimulus pushes the expected window results.
// The negedge monitor pops one entry and compares it on each output handshake.
module tb_sum_window_avg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_avg;
  logic [7:0] out_min;
  logic [7:0] out_max;
  logic [7:0] win_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] avg;
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] cnt;
  } res_t;

  res_t       sb[$];
  res_t       mon_e;
  logic [7:0] exp_win = '0;

  sum_window_avg #(.DATA_W(8), .LOG2_N(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_avg   (out_avg),
    .out_min   (out_min),
    .out_max   (out_max),
    .win_cnt   (win_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_result(input logic [7:0] a, input logic [7:0] mn, input logic [7:0] mx);
    res_t e;
    exp_win = exp_win + 8'd1;
    e.avg = a;
    e.mn  = mn;
    e.mx  = mx;
    e.cnt = exp_win;
    sb.push_back(e);
  endtask

  // Called at posedge+1. Returns at posedge+1 after the edge that accepted the sample.
  task automatic push_sample(input logic [7:0] v);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_avg"}, out_avg, 0);
    chk({tag, "_out_min"}, out_min, 0);
    chk({tag, "_out_max"}, out_max, 0);
    chk({tag, "_win_cnt"}, win_cnt, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  // Asserts reset between clock edges, checks that the outputs clear at once, then releases it
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero(tag);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    exp_win = '0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare against the scoreboard on every output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("res_avg", out_avg, mon_e.avg);
        chk("res_min", out_min, mon_e.mn);
        chk("res_max", out_max, mon_e.mx);
        chk("res_win_cnt", win_cnt, mon_e.cnt);
      end
    end
  end

  initial begin
    // Values checked while reset is held
    #2;
    chk_zero("reset");
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 10..80 back to back: sum 360, avg 45. The result must appear one cycle after the 8th sample.
    expect_result(8'd45, 8'd10, 8'd80);
    for (int i = 1; i <= 7; i++) push_sample(8'(i * 10));
    chk("pre_final_out_valid", out_valid, 0);
    push_sample(8'd80);
    chk("latency_out_valid", out_valid, 1);
    chk("latency_in_ready", in_ready, 0);
    idle(2);

    // 1 x7 and 2 with gaps: sum 9, avg 1 after truncation
    expect_result(8'd1, 8'd1, 8'd2);
    for (int i = 0; i < 8; i++) begin
      push_sample((i == 7) ? 8'd2 : 8'd1);
      idle($urandom_range(0, 3));
    end
    idle(2);

    // Eight samples of 254: the accumulator reaches 2032 without wrapping
    expect_result(8'd254, 8'd254, 8'd254);
    for (int i = 0; i < 8; i++) push_sample(8'd254);
    idle(2);

    // Hold the result for 5 cycles with 99 waiting on the input. Sum 16*7+24 = 136, avg 17.
    out_ready = 1'b0;
    expect_result(8'd17, 8'd16, 8'd24);
    for (int i = 0; i < 8; i++) push_sample((i == 3) ? 8'd24 : 8'd16);
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_avg", out_avg, 17);
      chk("hold_out_max", out_max, 24);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_avg_kept", out_avg, 17);
    // None of the 99s offered during the hold were taken, so this is a clean window
    expect_result(8'd99, 8'd99, 8'd99);
    for (int i = 0; i < 8; i++) push_sample(8'd99);
    idle(2);

    // Three samples of 50, then clear with a sample that must be dropped, then 8 x 200
    for (int i = 0; i < 3; i++) push_sample(8'd50);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd50;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_keeps_avg", out_avg, 99);
    expect_result(8'd200, 8'd200, 8'd200);
    for (int i = 0; i < 8; i++) push_sample(8'd200);
    idle(2);

    // Clear coincides with the 8th sample: no result, and win_cnt does not change
    for (int i = 0; i < 7; i++) push_sample(8'd200);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd200;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    idle(2);
    chk("clear_final_out_valid", out_valid, 0);
    chk("clear_final_win_cnt", win_cnt, exp_win);
    expect_result(8'd3, 8'd3, 8'd3);
    for (int i = 0; i < 8; i++) push_sample(8'd3);
    idle(2);

    // Reset partway through a window
    for (int i = 0; i < 5; i++) push_sample(8'd40);
    async_reset("rst_mid");
    out_ready = 1'b0;
    expect_result(8'd7, 8'd7, 8'd7);
    for (int i = 0; i < 8; i++) push_sample(8'd7);
    chk("hold_before_rst_valid", out_valid, 1);
    chk("hold_before_rst_win", win_cnt, 1);

    // Reset during HOLD: the held result is discarded and never emitted
    async_reset("rst_hold");
    void'(sb.pop_back());
    out_ready = 1'b1;
    expect_result(8'd7, 8'd7, 8'd7);
    for (int i = 0; i < 8; i++) push_sample(8'd7);
    idle(3);

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Stops the run if the stimulus gets stuck
  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
